mc_dp_pack: RTL and testbench

- Parametrised next-generation memory-controller data path. Sits between the Wishbone slave side and the memory pad interface.
- Packs narrow (8/16-bit) memory read beats into full words using an internal lane counter instead of external pack latch enables, and buffers them in a parametrised read FIFO.
- Generates real per-byte write parity, checks per-byte read parity, and flags FIFO overflow.

---
 rtl/mc_dp_pack_if.sv | 22 ++
 rtl/mc_dp_pack.sv | 183 ++++++++++++++++++
 tb/tb_mc_dp_pack.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_dp_pack_if.sv
// Wishbone-side bus bundle for the memory-controller data path.
interface mc_dp_pack_if #(
    parameter int unsigned DW = 32
) ();
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic          wb_we_i;
    logic          wb_ack_o;
    logic          wb_read_go;
    logic [DW-1:0] wb_data_i;
    logic [DW-1:0] wb_data_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o, wb_read_go, wb_data_i,
        input  wb_data_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o, wb_read_go, wb_data_i,
        output wb_data_o
    );
endinterface

// File: rtl/mc_dp_pack.sv
// Memory-controller data path: narrow read-beat packing, show-ahead read FIFO, byte parity.
// Optional macro MC_DP_ODD_PARITY_EN selects odd parity for generation and checking.
module mc_dp_pack #(
    parameter int unsigned DW      = 32,
    parameter int unsigned NB      = DW / 8,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      csc,
    mc_dp_pack_if.slave      wb,
    input  logic             mem_ack,
    input  logic [NB-1:0]    byte_en,
    input  logic [DW+NB-1:0] mc_data_del,
    input  logic             dv,
    output logic [DW-1:0]    mc_data_o,
    output logic [NB-1:0]    mc_dp_o,
    output logic             par_err,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic             fifo_ovf
);
    localparam int unsigned EW    = DW + NB;
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned CNTW  = FIFO_AW + 1;

    logic [2:0] mem_type;
    logic [1:0] bus_width;
    logic       pen;
    logic       clr;
    logic       unused_csc;

    assign mem_type   = csc[3:1];
    assign bus_width  = csc[5:4];
    assign pen        = csc[11];
    assign unused_csc = ^{csc[31:12], csc[10:6], csc[0]};
    assign clr        = !wb.wb_cyc_i | (wb.wb_we_i & wb.wb_stb_i);

    // Lane packer state
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] pack_data, asm_data;
    logic [NB-1:0] pack_par, asm_par;
    logic          pack_en, push;
    int unsigned   cnt_i;

    assign cnt_i = 32'(cnt);

    // Merge the current beat into the partial word; completing beat pushes the merged result.
    always_comb begin
        asm_data = pack_data;
        asm_par  = pack_par;
        cnt_nxt  = cnt;
        pack_en  = 1'b0;
        push     = 1'b0;
        if (dv) begin
            case (bus_width)
                2'd0: begin
                    pack_en = 1'b1;
                    for (int unsigned k = 0; k < NB; k++) begin
                        if (k == cnt_i) begin
                            asm_data[8*k +: 8] = mc_data_del[7:0];
                            asm_par[k]         = mc_data_del[DW];
                        end
                    end
                    if (cnt_i >= NB - 1) begin
                        push    = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                2'd1: begin
                    pack_en = 1'b1;
                    for (int unsigned k = 0; k < NB; k++) begin
                        if (k == cnt_i) begin
                            asm_data[8*k +: 8] = mc_data_del[7:0];
                            asm_par[k]         = mc_data_del[DW];
                        end else if (k == cnt_i + 1) begin
                            asm_data[8*k +: 8] = mc_data_del[15:8];
                            asm_par[k]         = mc_data_del[DW+1];
                        end
                    end
                    if (cnt_i + 1 >= NB - 1) begin
                        push    = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(2);
                    end
                end
                2'd2: begin
                    asm_data = mc_data_del[DW-1:0];
                    asm_par  = mc_data_del[EW-1:DW];
                    push     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            pack_data <= '0;
            pack_par  <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (pack_en) begin
            cnt       <= cnt_nxt;
            pack_data <= asm_data;
            pack_par  <= asm_par;
        end
    end

    // Read FIFO: parity bits stored alongside data
    logic [EW-1:0]      fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CNTW-1:0]    count;
    logic               re, we;
    logic [EW-1:0]      head;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNTW'(DEPTH));
    assign re         = wb.wb_ack_o & wb.wb_read_go & !fifo_empty;
    assign we         = push & (!fifo_full | re);
    assign head       = fifo_mem[rd_ptr];
    assign wb.wb_data_o = fifo_empty ? '0 : head[DW-1:0];

    always_ff @(posedge clk) begin
        if (!rst && !clr && we) begin
            fifo_mem[wr_ptr] <= {asm_par, asm_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fifo_ovf <= 1'b0;
        end else begin
            if (we) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (re) rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({we, re})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: ;
            endcase
            if (push && fifo_full && !re) fifo_ovf <= 1'b1;
        end
    end

    // Write path with per-byte parity generation
    logic [NB-1:0] dp_gen;
    logic [NB-1:0] par_bad;

    always_comb begin
        dp_gen  = '0;
        par_bad = '0;
        for (int unsigned k = 0; k < NB; k++) begin
`ifdef MC_DP_ODD_PARITY_EN
            dp_gen[k]  = ~(^wb.wb_data_i[8*k +: 8]);
            par_bad[k] = byte_en[k] & ~((^head[8*k +: 8]) ^ head[DW+k]);
`else
            dp_gen[k]  = ^wb.wb_data_i[8*k +: 8];
            par_bad[k] = byte_en[k] & ((^head[8*k +: 8]) ^ head[DW+k]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_data_o <= '0;
            mc_dp_o   <= '0;
        end else if (wb.wb_ack_o || (mem_type != 3'h0)) begin
            mc_data_o <= wb.wb_data_i;
            mc_dp_o   <= dp_gen;
        end
    end

    assign par_err = !wb.wb_we_i & mem_ack & pen & !fifo_empty & (|par_bad);

endmodule

// File: tb/tb_mc_dp_pack.sv
// Directed self-checking bench for mc_dp_pack (DW=32, FIFO depth 4).
module tb_mc_dp_pack;
    localparam int unsigned DW = 32;
    localparam int unsigned NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   csc;
    logic          mem_ack;
    logic [NB-1:0] byte_en;
    logic [DW+NB-1:0] mc_data_del;
    logic          dv;
    logic [DW-1:0] mc_data_o;
    logic [NB-1:0] mc_dp_o;
    logic          par_err, fifo_empty, fifo_full, fifo_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    mc_dp_pack_if #(.DW(DW)) wb ();

    mc_dp_pack #(.DW(DW), .FIFO_AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .csc        (csc),
        .wb         (wb),
        .mem_ack    (mem_ack),
        .byte_en    (byte_en),
        .mc_data_del(mc_data_del),
        .dv         (dv),
        .mc_data_o  (mc_data_o),
        .mc_dp_o    (mc_dp_o),
        .par_err    (par_err),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_ovf   (fifo_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] gen_par(input logic [31:0] d);
        logic [3:0] p;
        for (int k = 0; k < 4; k++) begin
`ifdef MC_DP_ODD_PARITY_EN
            p[k] = ~(^d[8*k +: 8]);
`else
            p[k] = ^d[8*k +: 8];
`endif
        end
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_p(input logic [31:0] d, input logic [3:0] p);
        dv          = 1'b1;
        mc_data_del = {p, d};
        tick();
        dv = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        beat_p(d, gen_par(d));
    endtask

    task automatic pop();
        wb.wb_ack_o   = 1'b1;
        wb.wb_read_go = 1'b1;
        tick();
        wb.wb_ack_o   = 1'b0;
        wb.wb_read_go = 1'b0;
    endtask

    task automatic clear();
        wb.wb_cyc_i = 1'b0;
        tick();
        wb.wb_cyc_i = 1'b1;
    endtask

    localparam logic [31:0] CSC_W8  = 32'h0000_0800;
    localparam logic [31:0] CSC_W16 = 32'h0000_0810;
    localparam logic [31:0] CSC_W32 = 32'h0000_0820;
    localparam logic [31:0] CSC_RSV = 32'h0000_0830;

    initial begin
        rst = 1'b1;
        csc = CSC_W32;
        mem_ack = 1'b0;
        byte_en = 4'hF;
        mc_data_del = '0;
        dv = 1'b0;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i = 1'b0;
        wb.wb_ack_o = 1'b0;
        wb.wb_read_go = 1'b0;
        wb.wb_data_i = '0;

        tick();
        tick();
        check("rst_empty", 64'(fifo_empty), 64'd1);
        check("rst_full", 64'(fifo_full), 64'd0);
        check("rst_ovf", 64'(fifo_ovf), 64'd0);
        check("rst_rdata", 64'(wb.wb_data_o), 64'd0);
        check("rst_mc_data", 64'(mc_data_o), 64'd0);
        check("rst_mc_dp", 64'(mc_dp_o), 64'd0);
        check("rst_par_err", 64'(par_err), 64'd0);
        rst = 1'b0;
        tick();

        // Full-width beats
        csc = CSC_W32;
        beat(32'h1122_3344);
        check("w32_head0", 64'(wb.wb_data_o), 64'h1122_3344);
        check("w32_nempty", 64'(fifo_empty), 64'd0);
        beat(32'hAABB_CCDD);
        mem_ack = 1'b1;
        #1;
        check("w32_par_ok", 64'(par_err), 64'd0);
        mem_ack = 1'b0;
        pop();
        check("w32_head1", 64'(wb.wb_data_o), 64'hAABB_CCDD);
        pop();
        check("w32_drained", 64'(fifo_empty), 64'd1);
        pop();
        check("pop_on_empty", 64'(fifo_empty), 64'd1);

        // 8-bit packing, little-endian lanes
        csc = CSC_W8;
        beat(32'h44);
        beat(32'h33);
        beat(32'h22);
        check("w8_no_push", 64'(fifo_empty), 64'd1);
        beat(32'h11);
        check("w8_word", 64'(wb.wb_data_o), 64'h1122_3344);
        pop();
        beat(32'h01);
        beat(32'h02);
        beat(32'h03);
        beat(32'h04);
        check("w8_cnt_wrap", 64'(wb.wb_data_o), 64'h0403_0201);
        pop();

        // 16-bit packing with idle gaps
        csc = CSC_W16;
        beat(32'hCCDD);
        tick();
        tick();
        tick();
        check("w16_no_push", 64'(fifo_empty), 64'd1);
        beat(32'hAABB);
        check("w16_word", 64'(wb.wb_data_o), 64'hAABB_CCDD);
        pop();
        check("w16_drained", 64'(fifo_empty), 64'd1);

        // Reserved width ignores beats
        csc = CSC_RSV;
        for (int i = 0; i < 5; i++) beat(32'h5555_0000 + 32'(i));
        check("rsv_ignored", 64'(fifo_empty), 64'd1);

        // Overflow at depth 4
        csc = CSC_W32;
        for (int i = 0; i < 4; i++) beat(32'h1000_0000 + 32'(i));
        check("ovf_full4", 64'(fifo_full), 64'd1);
        check("ovf_not_yet", 64'(fifo_ovf), 64'd0);
        beat(32'h1000_0004);
        check("ovf_set", 64'(fifo_ovf), 64'd1);
        check("ovf_head", 64'(wb.wb_data_o), 64'h1000_0000);
        clear();
        check("clr_empty", 64'(fifo_empty), 64'd1);
        check("clr_ovf", 64'(fifo_ovf), 64'd0);
        check("clr_full", 64'(fifo_full), 64'd0);

        // Push and pop together when full
        for (int i = 0; i < 4; i++) beat(32'h2000_0000 + 32'(i));
        wb.wb_ack_o   = 1'b1;
        wb.wb_read_go = 1'b1;
        beat(32'h2000_0004);
        wb.wb_ack_o   = 1'b0;
        wb.wb_read_go = 1'b0;
        check("pp_full", 64'(fifo_full), 64'd1);
        check("pp_no_ovf", 64'(fifo_ovf), 64'd0);
        check("pp_head", 64'(wb.wb_data_o), 64'h2000_0001);
        clear();

        // Read parity error on lane 0
        beat_p(32'h0000_00FF, gen_par(32'h0000_00FF) ^ 4'b0001);
        mem_ack = 1'b1;
        byte_en = 4'b0001;
        #1;
        check("perr_lane0", 64'(par_err), 64'd1);
        byte_en = 4'b1110;
        #1;
        check("perr_masked", 64'(par_err), 64'd0);
        byte_en = 4'b0001;
        csc = 32'h0000_0020;
        #1;
        check("perr_pen_off", 64'(par_err), 64'd0);
        csc = CSC_W32;
        wb.wb_we_i = 1'b1;
        #1;
        check("perr_write", 64'(par_err), 64'd0);
        wb.wb_we_i = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("perr_no_ack", 64'(par_err), 64'd0);
        byte_en = 4'hF;
        clear();

        // Write path parity
        wb.wb_data_i = 32'h0103_0700;
        wb.wb_ack_o  = 1'b1;
        tick();
        wb.wb_ack_o  = 1'b0;
        check("wr_data", 64'(mc_data_o), 64'h0103_0700);
`ifdef MC_DP_ODD_PARITY_EN
        check("wr_par", 64'(mc_dp_o), 64'b0101);
`else
        check("wr_par", 64'(mc_dp_o), 64'b1010);
`endif
        wb.wb_data_i = 32'hDEAD_BEEF;
        tick();
        check("wr_hold_sdram", 64'(mc_data_o), 64'h0103_0700);
        csc = CSC_W32 | 32'h2;
        wb.wb_data_i = 32'h0000_0080;
        tick();
        check("wr_nonsdram", 64'(mc_data_o), 64'h0000_0080);
`ifdef MC_DP_ODD_PARITY_EN
        check("wr_par_ns", 64'(mc_dp_o), 64'b1110);
`else
        check("wr_par_ns", 64'(mc_dp_o), 64'b0001);
`endif

        // Reset mid-packing
        csc = CSC_W8;
        beat(32'hAA);
        beat(32'hBB);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_empty", 64'(fifo_empty), 64'd1);
        check("rst_mid_mcdata", 64'(mc_data_o), 64'd0);
        beat(32'h44);
        beat(32'h33);
        beat(32'h22);
        check("rst_mid_nopush", 64'(fifo_empty), 64'd1);
        beat(32'h11);
        check("rst_mid_word", 64'(wb.wb_data_o), 64'h1122_3344);
        pop();
        check("rst_mid_single", 64'(fifo_empty), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
